// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: write-arbiter ownership encoding and default sizing.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } own_state_e;

    localparam int unsigned FIFO_BITS  = 8;
    localparam int unsigned FIFO_BURST = 4;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/rr_pick.sv
// Idle tie-break: a lone requester wins, a tie goes to the producer
// that did not own the FIFO last.
module rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic pick_o
);

    assign valid_o = req0_i | req1_i;
    assign pick_o  = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-producer FIFO write arbiter with bounded bursts and
// round-robin hand-over between producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned bits  = FIFO_BITS,
    parameter int unsigned burst = FIFO_BURST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [bits-1:0] din0,
    input  logic [bits-1:0] din1,
    output logic            gnt0,
    output logic            gnt1,
    input  logic            full,
    output logic            push,
    output logic [bits-1:0] fifo_din,
    output logic [1:0]      owner
);

    localparam logic [CNT_W-1:0] BurstMax = CNT_W'(burst);

    own_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             last_q, last_d;

    logic own0, own1, req_own, req_oth, xfer, xfer_g;
    logic pick_valid, pick;

    rr_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
        .last_i (last_q),
        .valid_o(pick_valid),
        .pick_o (pick)
    );

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign req_own = (own0 & req0) | (own1 & req1);
    assign req_oth = (own0 & req1) | (own1 & req0);
    assign xfer    = req_own & ~full;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = pick ? OWN1 : OWN0;
                    cnt_d   = '0;
                    last_d  = pick;
                end
            end
            OWN0, OWN1: begin
                if (!req_own || (xfer && cnt_inc == BurstMax)) begin
                    cnt_d = '0;
                    if (req_oth) begin
                        state_d = own0 ? OWN1 : OWN0;
                        last_d  = own0;
                    end else if (!req_own) begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Reset masks the outputs in the same cycle so a mid-burst reset never pushes.
    assign xfer_g = xfer & ~rst;
    assign push   = xfer_g;
    assign gnt0   = xfer_g & own0;
    assign gnt1   = xfer_g & own1;
    assign owner  = rst ? 2'b00 : state_q;

    always_comb begin
        fifo_din = '0;
        if (gnt0) fifo_din = din0;
        else if (gnt1) fifo_din = din1;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle vector table plus a
// scoreboarded single-producer stream.
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1, full;
    logic [7:0] din0, din1;
    logic       gnt0, gnt1, push;
    logic [7:0] fifo_din;
    logic [1:0] owner;

    int tests = 0;
    int fails = 0;

    fifo_wr_arbiter #(.bits(8), .burst(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .din0    (din0),
        .din1    (din1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .full    (full),
        .push    (push),
        .fifo_din(fifo_din),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, r0, r1, full;
        logic [7:0] d0, d1;
        logic       push, g0, g1;
        logic [7:0] fd;
        logic [1:0] own;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] expq[$];

    function automatic vec_t mk(
        input logic rs, input logic r0, input logic r1, input logic fl,
        input logic [7:0] d0, input logic p, input logic g0,
        input logic g1, input logic [7:0] fd, input logic [1:0] own);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.full = fl;
        v.d0 = d0; v.d1 = 8'h22;
        v.push = p; v.g0 = g0; v.g1 = g1; v.fd = fd; v.own = own;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int idx, npush, bubbles, queued;
        logic [7:0] w;

        // reset
        vecs.push_back(mk(1,0,0,0,8'hA5, 0,0,0,8'h00,2'b00));
        vecs.push_back(mk(1,0,0,0,8'hA5, 0,0,0,8'h00,2'b00));
        // lone producer 0: one idle cycle, then push A5
        vecs.push_back(mk(0,1,0,0,8'hA5, 0,0,0,8'h00,2'b00));
        vecs.push_back(mk(0,1,0,0,8'hA5, 1,1,0,8'hA5,2'b01));
        vecs.push_back(mk(0,0,0,0,8'hA5, 0,0,0,8'h00,2'b01));
        vecs.push_back(mk(0,0,0,0,8'hA5, 0,0,0,8'h00,2'b00));
        vecs.push_back(mk(1,0,0,0,8'h11, 0,0,0,8'h00,2'b00));
        // both requesting: runs of 4, producer 0 first
        vecs.push_back(mk(0,1,1,0,8'h11, 0,0,0,8'h00,2'b00));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,1,0,8'h11, 1,1,0,8'h11,2'b01));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,1,0,8'h11, 1,0,1,8'h22,2'b10));
        vecs.push_back(mk(0,1,1,0,8'h11, 1,1,0,8'h11,2'b01));
        // stall 3 cycles mid-burst, then 3 remaining pushes
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,1,8'h11, 0,0,0,8'h00,2'b01));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,0,8'h11, 1,1,0,8'h11,2'b01));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,1,1,0,8'h11, 1,0,1,8'h22,2'b10));
        // req0 drops while full: hand over to producer 1, no push
        vecs.push_back(mk(0,0,1,1,8'h11, 0,0,0,8'h00,2'b01));
        vecs.push_back(mk(0,0,1,1,8'h11, 0,0,0,8'h00,2'b10));
        vecs.push_back(mk(0,0,1,0,8'h11, 1,0,1,8'h22,2'b10));
        vecs.push_back(mk(0,0,1,0,8'h11, 1,0,1,8'h22,2'b10));
        // reset at cnt=2 of OWN1, then tie goes to producer 0
        vecs.push_back(mk(1,1,1,0,8'h11, 0,0,0,8'h00,2'b00));
        vecs.push_back(mk(0,1,1,0,8'h11, 0,0,0,8'h00,2'b00));
        vecs.push_back(mk(0,1,1,0,8'h11, 1,1,0,8'h11,2'b01));
        vecs.push_back(mk(0,0,0,0,8'h11, 0,0,0,8'h00,2'b01));
        vecs.push_back(mk(0,0,0,0,8'h11, 0,0,0,8'h00,2'b00));

        rst = 1; req0 = 0; req1 = 0; full = 0; din0 = '0; din1 = '0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;  req0 = vecs[i].r0;
            req1 = vecs[i].r1;   full = vecs[i].full;
            din0 = vecs[i].d0;   din1 = vecs[i].d1;
            @(negedge clk);
            tests++;
            if (push !== vecs[i].push || gnt0 !== vecs[i].g0 ||
                gnt1 !== vecs[i].g1 || fifo_din !== vecs[i].fd ||
                owner !== vecs[i].own) begin
                fails++;
                $display("FAIL row%0d: push/g0/g1/din/own got %b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
                         i, push, gnt0, gnt1, fifo_din, owner,
                         vecs[i].push, vecs[i].g0, vecs[i].g1,
                         vecs[i].fd, vecs[i].own);
            end
            @(posedge clk); #1;
        end

        // 10-word stream from producer 0: no bubble at burst boundaries
        idx = 0; npush = 0; bubbles = 0; queued = -1;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            rst = 0; req1 = 0; full = 0;
            req0 = 1'b1;
            din0 = 8'h40 + 8'(idx);
            if (queued != idx) begin
                expq.push_back(din0);
                queued = idx;
            end
            @(negedge clk);
            if (push) begin
                npush++;
                if (expq.size() == 0) begin
                    chk("stream_unexpected_push", 32'(fifo_din), 32'hFFFF);
                end else begin
                    w = expq.pop_front();
                    chk("stream_data", 32'(fifo_din), 32'(w));
                    chk("stream_gnt", {30'd0, gnt1, gnt0}, 32'b01);
                end
            end else if (npush > 0) begin
                bubbles++;
            end
            if (gnt0) idx++;
            @(posedge clk); #1;
        end
        if (idx < 10) chk("stream_timeout", 32'(idx), 32'd10);
        chk("stream_pushes", 32'(npush), 32'd10);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_queue_left", 32'(expq.size()), 32'd0);

        req0 = 0;
        @(negedge clk);
        chk("stream_end_push", {31'd0, push}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_end_owner", {30'd0, owner}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
